// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, request states, entry type and sizing helpers for the fetch front end
package fetch_pkg;
    localparam int OPC_W = 4;
    localparam logic [OPC_W-1:0] HLT_OPC = 4'hF;
    typedef enum logic [1:0] {IDLE, REQ, REQ_DROP} req_state_t;
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: memory request bus, decode stream and redirect signals of the fetch unit
interface fetch_queue_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    logic                       mem_req;
    logic [ADDR_W-1:0]          mem_addr;
    logic                       mem_ack;
    logic [DATA_W-1:0]          mem_rdata;
    logic                       inst_valid;
    logic [DATA_W-1:0]          inst_data;
    logic [ADDR_W-1:0]          inst_pc;
    logic                       inst_ready;
    logic                       redirect;
    logic [ADDR_W-1:0]          redirect_pc;
    logic                       hlt_fetched;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    modport master (
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc, hlt_fetched, occupancy,
        input  mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
    );
    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, hlt_fetched, occupancy,
        output mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: register-based FIFO with occupancy count and synchronous flush
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];
    // storage is only written on push, so its contents need no reset
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    // pointers and count; flush overrides push and pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push) - CNT_W'(pop);
        end
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC sequencer, single-outstanding memory request FSM and prefetch queue to decode
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OPC_W-1:0]  HLT_OPC  = fetch_pkg::HLT_OPC
) (
    input logic                clk,
    input logic                rst_n,
    fetch_queue_unit_if.master bus
);
    localparam int CNT_W = cnt_w(DEPTH);
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;
    req_state_t        state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, req_addr;
    logic              run, hlt, issue, push, pop, full, empty;
    logic [CNT_W-1:0]  count;
    entry_t            din, dout;
    assign din  = '{pc: bus.mem_addr, instr: bus.mem_rdata};
    assign pop  = !empty && bus.inst_ready;
    assign push = bus.mem_req && bus.mem_ack && state != REQ_DROP && !bus.redirect;
    sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign bus.inst_valid  = !empty;
    assign bus.inst_data   = dout.instr;
    assign bus.inst_pc     = dout.pc;
    assign bus.hlt_fetched = hlt;
    assign bus.occupancy   = count;
    // request FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    // an unacked live request stays outstanding; once a redirect hits it, its response is discarded
    always_comb
        state_nx = (bus.mem_req && !bus.mem_ack) ? ((bus.redirect || state == REQ_DROP) ? REQ_DROP : REQ) : IDLE;
    // issue from registered state only; the address is held from the issue cycle until the ack
    always_comb begin
        issue        = run && state == IDLE && !hlt && !full;
        bus.mem_req  = state != IDLE || issue;
        bus.mem_addr = (state == IDLE) ? fetch_pc : req_addr;
    end
    // PC sequencer, held request address, halt pre-detection; run keeps mem_req low through reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            hlt      <= 1'b0;
        end else begin
            run      <= 1'b1;
            req_addr <= bus.mem_addr;
            fetch_pc <= bus.redirect ? bus.redirect_pc : push ? bus.mem_addr + ADDR_W'(PC_INC) : fetch_pc;
            hlt      <= !bus.redirect && (hlt || (push && bus.mem_rdata[DATA_W-1 -: OPC_W] == HLT_OPC));
        end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed scoreboard bench for the fetch front end with a variable-latency memory model
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          cnt;
    logic        stray = 1'b0;
    logic [15:0] hlt_addr = 16'hFFFF;
    logic [15:0] exp_q[$];

    fetch_queue_unit_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH)) bus ();

    fetch_queue_unit #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .PC_INC(2), .RESET_PC(16'h0000), .HLT_OPC(4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rdata(input logic [15:0] a, input logic [15:0] h);
        return (a == h) ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    // memory model: ack in the lat-th cycle of a request (lat=1 is a combinational ack)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= 0;
        else        cnt <= (bus.mem_req && !bus.mem_ack) ? cnt + 1 : 0;

    always_comb begin
        bus.mem_ack   = stray || (bus.mem_req && cnt >= lat - 1);
        bus.mem_rdata = rdata(bus.mem_addr, hlt_addr);
    end

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_req && !bus.mem_ack |=> bus.mem_req && $stable(bus.mem_addr))
        else begin failures++; $error("FAIL addr_stable observed=%h", bus.mem_addr); end
    a_occ_max: assert property (@(posedge clk) bus.occupancy <= DEPTH)
        else begin failures++; $error("FAIL occ_max observed=%0d expected<=%0d", bus.occupancy, DEPTH); end
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        bus.occupancy == DEPTH |-> !bus.mem_req)
        else begin failures++; $error("FAIL no_push_full observed mem_req=%b expected=0", bus.mem_req); end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_run(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 16'(2 * i));
    endtask

    task automatic do_reset(input int l);
        rst_n           = 1'b0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        stray           = 1'b0;
        lat             = l;
        hlt_addr        = 16'hFFFF;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_occ(input int occ, input string tag);
        int t = 0;
        while (bus.occupancy != 3'(occ) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(bus.occupancy), 32'(occ));
    endtask

    // pop and compare every scoreboard entry; ready is raised only for a head that is being checked
    task automatic drain(input string tag, output int span);
        int t = 0;
        int first = -1;
        logic [15:0] e;
        span = -1;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
            if (bus.inst_valid) begin
                e = exp_q.pop_front();
                check({tag, "_pc"}, 32'(bus.inst_pc), 32'(e));
                check({tag, "_data"}, 32'(bus.inst_data), 32'(rdata(e, hlt_addr)));
                if (first < 0) first = t;
                span = t - first;
            end
            bus.inst_ready = bus.inst_valid;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=%0d left expected=0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        int span;
        int t;
        // 1: reset values, zero-wait streaming
        do_reset(1);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0000);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_hlt", 32'(bus.hlt_fetched), 32'd0);
        rst_n = 1'b1;
        expect_run(16'h0000, 8);
        wait_occ(4, "t1_fill");
        drain("t1", span);
        check("t1_span", 32'(span), 32'd7);
        // 2: back-pressure with 2-cycle memory
        do_reset(2);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t2_occ", 32'(bus.occupancy), 32'd4);
        check("t2_req", 32'(bus.mem_req), 32'd0);
        expect_run(16'h0000, 6);
        drain("t2", span);
        // 3: redirect while 0x0008 is outstanding (3-cycle memory)
        do_reset(3);
        rst_n = 1'b1;
        wait_occ(4, "t3_fill");
        expect_run(16'h0000, 1);
        drain("t3_pre", span);
        t = 0;
        while (!(bus.mem_req && bus.mem_addr == 16'h0008) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t3_req8", 32'({bus.mem_req, bus.mem_addr}), 32'h1_0008);
        check("t3_req8_noack", 32'(bus.mem_ack), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("t3_flush_occ", 32'(bus.occupancy), 32'd0);
        check("t3_flush_valid", 32'(bus.inst_valid), 32'd0);
        check("t3_hold", 32'({bus.mem_req, bus.mem_addr}), 32'h1_0008);
        expect_run(16'h0040, 2);
        drain("t3", span);
        // 4: HLT at 0x000A stops fetching; redirect resumes
        do_reset(1);
        hlt_addr = 16'h000A;
        rst_n = 1'b1;
        expect_run(16'h0000, 6);
        drain("t4", span);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_no_req", 32'(bus.mem_req), 32'd0);
        end
        check("t4_hlt", 32'(bus.hlt_fetched), 32'd1);
        check("t4_occ", 32'(bus.occupancy), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0020;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("t4_hlt_clr", 32'(bus.hlt_fetched), 32'd0);
        expect_run(16'h0020, 2);
        drain("t4_resume", span);
        // 5: address wrap
        do_reset(1);
        rst_n = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFC;
        @(negedge clk);
        bus.redirect = 1'b0;
        expect_run(16'hFFFC, 3);
        drain("t5", span);
        // 6: reset mid-request and a stray ack
        do_reset(3);
        rst_n = 1'b1;
        expect_run(16'h0000, 2);
        drain("t6_pre", span);
        t = 0;
        while (!(bus.mem_req && !bus.mem_ack) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t6_midreq", 32'(bus.mem_req && !bus.mem_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(bus.mem_req), 32'd0);
        check("t6_addr", 32'(bus.mem_addr), 32'h0000);
        check("t6_valid", 32'(bus.inst_valid), 32'd0);
        check("t6_occ", 32'(bus.occupancy), 32'd0);
        check("t6_hlt", 32'(bus.hlt_fetched), 32'd0);
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("t6_stray_occ", 32'(bus.occupancy), 32'd0);
        check("t6_stray_valid", 32'(bus.inst_valid), 32'd0);
        expect_run(16'h0000, 2);
        drain("t6", span);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
